tlp_tx_arb: RTL and testbench

Packet-granular arbiter for the single 64-bit PCIe transmit stream. It shares the FPGA->CPU TLP path between these sources inside `tlp_xcvr`:

- register-read completions;
- F2C DMA write TLPs (2 header QWs + 16 data QWs);
- meter/write-pointer update TLPs.

It grants whole packets (SOP..EOP) without interleaving, gives strict priority to selected requesters and round-robin to the rest. Output goes through a registered two-entry buffer that drives `txData/txValid/txSOP/txEOP` toward the hard IP.

---
 rtl/tlp_xcvr_pkg.sv | 31 +++
 rtl/tlp_tx_skid.sv | 49 ++++
 rtl/tlp_tx_arb.sv | 138 +++++++++++++
 tb/tb_tlp_tx_arb.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlp_xcvr_pkg.sv
// Shared types for the FPGA->CPU TLP transmit path.
package tlp_xcvr_pkg;

   typedef logic [63:0] uint64;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } ArbState;

   // One transmit beat: 64-bit payload plus packet framing (66 bits).
   typedef struct packed {
      uint64 data;
      logic  sop;
      logic  eop;
   } TxBeat;

   // Completions (requester 0) are strict priority by default.
   localparam logic [2:0] DEFAULT_HIPRI_MASK = 3'b001;

   // (a + b) mod n for a, b < n, without a divider.
   function automatic int unsigned wrapAdd(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned n);
      int unsigned s;
      s = a + b;
      if (s >= n) s = s - n;
      return s;
   endfunction

endpackage

// File: rtl/tlp_tx_skid.sv
// Two-entry TxBeat buffer; the head entry drives the transmit outputs directly.
module tlp_tx_skid
   import tlp_xcvr_pkg::*;
(
   input  logic  sysClk,
   input  logic  reset,
   input  logic  push,
   input  TxBeat pushBeat,
   input  logic  pop,
   output TxBeat headBeat,
   output logic  full,
   output logic  empty
);

   TxBeat      mem [2];
   logic       wrPtr;
   logic       rdPtr;
   logic [1:0] count;
   logic       doPush;
   logic       doPop;

   assign full     = (count == 2'd2);
   assign empty    = (count == 2'd0);
   assign doPush   = push & ~full;
   assign doPop    = pop & ~empty;
   assign headBeat = mem[rdPtr];

   // Storage, pointers and occupancy; the head only moves on a pop, so it is stable while stalled.
   always_ff @(posedge sysClk) begin
      if (reset) begin
         mem   <= '{default: '0};
         wrPtr <= 1'b0;
         rdPtr <= 1'b0;
         count <= 2'd0;
      end else begin
         if (doPush) begin
            mem[wrPtr] <= pushBeat;
            wrPtr      <= ~wrPtr;
         end
         if (doPop) rdPtr <= ~rdPtr;
         case ({doPush, doPop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tlp_tx_arb.sv
// Packet-granular arbiter for the 64-bit TLP transmit stream: strict priority
// for HIPRI requesters, round-robin for the rest, no interleaving within a packet.
module tlp_tx_arb
   import tlp_xcvr_pkg::*;
#(
   parameter int unsigned         NUM_REQ    = 3,
   parameter logic [NUM_REQ-1:0]  HIPRI_MASK = NUM_REQ'(DEFAULT_HIPRI_MASK)
)(
   input  logic                      clk_in,
   input  logic                      reset_in,
   input  logic [NUM_REQ-1:0][63:0]  reqData_in,
   input  logic [NUM_REQ-1:0]        reqValid_in,
   input  logic [NUM_REQ-1:0]        reqSOP_in,
   input  logic [NUM_REQ-1:0]        reqEOP_in,
   output logic [NUM_REQ-1:0]        reqReady_out,
   output logic [63:0]               txData_out,
   output logic                      txValid_out,
   output logic                      txSOP_out,
   output logic                      txEOP_out,
   input  logic                      txReady_in,
   output logic [NUM_REQ-1:0]        grant_out,
   output logic                      protoErr_out
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   ArbState              state;
   logic [PTR_W-1:0]     rrPtr;
   logic [PTR_W-1:0]     ownerIdx;
   logic [NUM_REQ-1:0]   ownerOh;
   logic                 protoErr;

   logic [NUM_REQ-1:0]   eligible;
   logic                 winFound;
   logic [PTR_W-1:0]     winIdx;
   logic [PTR_W-1:0]     rrIdx;
   logic [NUM_REQ-1:0]   winOh;
   logic                 winHi;

   logic [PTR_W-1:0]     selIdx;
   logic                 push;
   logic                 pop;
   TxBeat                pushBeat;
   TxBeat                headBeat;
   logic                 bufFull;
   logic                 bufEmpty;

   // IDLE arbitration: lowest-index HIPRI SOP first, else cyclic search from rrPtr over the rest.
   always_comb begin
      eligible = reqValid_in & reqSOP_in;
      winFound = 1'b0;
      winIdx   = '0;
      rrIdx    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!winFound && eligible[PTR_W'(i)] && HIPRI_MASK[PTR_W'(i)]) begin
            winFound = 1'b1;
            winIdx   = PTR_W'(i);
         end
      end
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         rrIdx = PTR_W'(wrapAdd(32'(rrPtr), k, NUM_REQ));
         if (!winFound && eligible[rrIdx] && !HIPRI_MASK[rrIdx]) begin
            winFound = 1'b1;
            winIdx   = rrIdx;
         end
      end
      winOh = '0;
      if (winFound) winOh[winIdx] = 1'b1;
      winHi = HIPRI_MASK[winIdx];
   end

   // Ready and grant: depend only on state, arbitration and buffer fullness, never on txReady_in.
   always_comb begin
      reqReady_out = '0;
      grant_out    = '0;
      if (!reset_in) begin
         grant_out = (state == LOCKED) ? ownerOh : winOh;
         if (!bufFull) reqReady_out = (state == LOCKED) ? ownerOh : winOh;
      end
   end

   assign selIdx   = (state == LOCKED) ? ownerIdx : winIdx;
   assign push     = |(reqReady_out & reqValid_in);
   assign pop      = txValid_out & txReady_in;
   assign pushBeat = '{data: reqData_in[selIdx], sop: reqSOP_in[selIdx], eop: reqEOP_in[selIdx]};

   // Packet ownership FSM, round-robin pointer and sticky protocol-error flag.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state    <= IDLE;
         rrPtr    <= '0;
         ownerIdx <= '0;
         ownerOh  <= '0;
         protoErr <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (push) begin
                  if (!reqEOP_in[winIdx]) begin
                     state    <= LOCKED;
                     ownerIdx <= winIdx;
                     ownerOh  <= winOh;
                  end
                  if (!winHi) rrPtr <= PTR_W'(wrapAdd(32'(winIdx), 1, NUM_REQ));
               end
            end
            LOCKED: begin
               if (push) begin
                  if (reqSOP_in[ownerIdx]) protoErr <= 1'b1;
                  if (reqEOP_in[ownerIdx]) begin
                     state   <= IDLE;
                     ownerOh <= '0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   tlp_tx_skid uSkid (
      .sysClk   (clk_in),
      .reset    (reset_in),
      .push     (push),
      .pushBeat (pushBeat),
      .pop      (pop),
      .headBeat (headBeat),
      .full     (bufFull),
      .empty    (bufEmpty)
   );

   assign txValid_out  = ~bufEmpty;
   assign txData_out   = headBeat.data;
   assign txSOP_out    = headBeat.sop & ~bufEmpty;
   assign txEOP_out    = headBeat.eop & ~bufEmpty;
   assign protoErr_out = protoErr;

endmodule

// File: tb/tb_tlp_tx_arb.sv
// Directed scoreboard bench for tlp_tx_arb.
module tb_tlp_tx_arb;

   typedef struct {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic        first;
   } Beat_t;

   localparam logic [15:0] FPGA_ID = 16'hA5C3;
   localparam logic [63:0] MTRBASE = 64'h0000_0000_0004_1000;
   localparam logic [63:0] MHDR    = 64'h4000_0004_0000_0002;

   logic             clk_in = 1'b0;
   logic             reset_in;
   logic [2:0][63:0] reqData_in;
   logic [2:0]       reqValid_in;
   logic [2:0]       reqSOP_in;
   logic [2:0]       reqEOP_in;
   logic [2:0]       reqReady_out;
   logic [63:0]      txData_out;
   logic             txValid_out;
   logic             txSOP_out;
   logic             txEOP_out;
   logic             txReady_in;
   logic [2:0]       grant_out;
   logic             protoErr_out;

   always #5 clk_in = ~clk_in;

   tlp_tx_arb #(.NUM_REQ(3), .HIPRI_MASK(3'b001)) dut (
      .clk_in       (clk_in),
      .reset_in     (reset_in),
      .reqData_in   (reqData_in),
      .reqValid_in  (reqValid_in),
      .reqSOP_in    (reqSOP_in),
      .reqEOP_in    (reqEOP_in),
      .reqReady_out (reqReady_out),
      .txData_out   (txData_out),
      .txValid_out  (txValid_out),
      .txSOP_out    (txSOP_out),
      .txEOP_out    (txEOP_out),
      .txReady_in   (txReady_in),
      .grant_out    (grant_out),
      .protoErr_out (protoErr_out)
   );

   Beat_t       srcQ [3][$];
   Beat_t       sbQ [$];
   int          ordExp [$];
   int          nCmp = 0;
   int          nErr = 0;
   int          cyc = 0;
   logic        stallPrev = 1'b0;
   logic [63:0] prevData;
   logic        prevSop, prevEop;
   logic        txRand = 1'b0;
   logic        txHold = 1'b1;
   logic        expGrantOn = 1'b0;
   logic [2:0]  expGrant = '0;
   int          accCount, accFirst, accLast, txCount, txFirst, txLast;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic Beat_t mk(input logic [63:0] d, input logic s, input logic e, input logic f);
      Beat_t b;
      b.data = d; b.sop = s; b.eop = e; b.first = f;
      return b;
   endfunction

   task automatic addPkt(input int r, input int n, input logic [63:0] base);
      for (int j = 0; j < n; j++)
         srcQ[r].push_back(mk(base + 64'(j), j == 0, j == n - 1, j == 0));
   endtask

   task automatic clrStats();
      accCount = 0; accFirst = 0; accLast = 0;
      txCount = 0;  txFirst = 0;  txLast = 0;
   endtask

   task automatic drive();
      Beat_t b;
      for (int i = 0; i < 3; i++) begin
         if (srcQ[i].size() > 0) begin
            b = srcQ[i][0];
            reqValid_in[i] = 1'b1;
            reqData_in[i]  = b.data;
            reqSOP_in[i]   = b.sop;
            reqEOP_in[i]   = b.eop;
         end else begin
            reqValid_in[i] = 1'b0;
            reqData_in[i]  = '0;
            reqSOP_in[i]   = 1'b0;
            reqEOP_in[i]   = 1'b0;
         end
      end
      txReady_in = txRand ? 1'($urandom_range(0, 1)) : txHold;
   endtask

   // One clock: observe at the falling edge, then re-drive just after the rising edge.
   task automatic step();
      Beat_t b;
      int    e;
      @(negedge clk_in);
      cyc++;
      if (stallPrev) begin
         check("stallValid", 64'(txValid_out), 64'(1));
         check("stallData", txData_out, prevData);
         check("stallSop", 64'(txSOP_out), 64'(prevSop));
         check("stallEop", 64'(txEOP_out), 64'(prevEop));
      end
      if (txValid_out && txReady_in) begin
         if (sbQ.size() == 0) begin
            check("txUnexpected", 64'(txValid_out), 64'(0));
         end else begin
            b = sbQ.pop_front();
            check("txData", txData_out, b.data);
            check("txSop", 64'(txSOP_out), 64'(b.sop));
            check("txEop", 64'(txEOP_out), 64'(b.eop));
         end
         if (txCount == 0) txFirst = cyc;
         txLast = cyc;
         txCount++;
      end
      stallPrev = txValid_out && !txReady_in;
      prevData  = txData_out;
      prevSop   = txSOP_out;
      prevEop   = txEOP_out;
      if (expGrantOn && reqValid_in != 3'b000) check("grant", 64'(grant_out), 64'(expGrant));
      if ($countones(reqReady_out) > 1) check("readyOneHot", 64'(reqReady_out), 64'(0));
      for (int i = 0; i < 3; i++) begin
         if (reqValid_in[i] && reqReady_out[i]) begin
            b = srcQ[i].pop_front();
            sbQ.push_back(b);
            if (b.first) begin
               e = (ordExp.size() > 0) ? ordExp.pop_front() : -1;
               check("grantOrder", 64'(i), 64'(e));
            end
            if (accCount == 0) accFirst = cyc;
            accLast = cyc;
            accCount++;
         end
      end
      @(posedge clk_in);
      #1;
      drive();
   endtask

   task automatic runDrain(input string tag, input int maxCyc);
      int n = 0;
      while ((srcQ[0].size() + srcQ[1].size() + srcQ[2].size() + sbQ.size()) != 0 && n < maxCyc) begin
         step();
         n++;
      end
      check(tag, 64'(srcQ[0].size() + srcQ[1].size() + srcQ[2].size() + sbQ.size()), 64'(0));
      check("orderLeft", 64'(ordExp.size()), 64'(0));
   endtask

   task automatic checkResetOutputs(input string tag);
      check({tag, "TxValid"}, 64'(txValid_out), 64'(0));
      check({tag, "TxData"}, txData_out, 64'(0));
      check({tag, "TxSop"}, 64'(txSOP_out), 64'(0));
      check({tag, "TxEop"}, 64'(txEOP_out), 64'(0));
      check({tag, "Ready"}, 64'(reqReady_out), 64'(0));
      check({tag, "Grant"}, 64'(grant_out), 64'(0));
      check({tag, "ProtoErr"}, 64'(protoErr_out), 64'(0));
   endtask

   // Pulse reset for one cycle, discarding everything the bench had in flight.
   task automatic pulseReset();
      reset_in = 1'b1;
      for (int i = 0; i < 3; i++) srcQ[i].delete();
      sbQ.delete();
      ordExp.delete();
      stallPrev = 1'b0;
      drive();
      txReady_in = 1'b0;
      @(posedge clk_in);
      #1;
      reset_in = 1'b0;
      txReady_in = 1'b1;
      @(negedge clk_in);
      checkResetOutputs("rst");
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_in    = 1'b1;
      reqData_in  = '0;
      reqValid_in = '0;
      reqSOP_in   = '0;
      reqEOP_in   = '0;
      txReady_in  = 1'b1;
      clrStats();
      repeat (3) @(posedge clk_in);
      #1;
      reset_in = 1'b0;
      @(negedge clk_in);
      checkResetOutputs("init");
      @(posedge clk_in);
      #1;

      // 18-beat DMA write on requester 1, txReady held high
      clrStats();
      srcQ[1].push_back(mk({FPGA_ID, 48'h00FF40000020}, 1'b1, 1'b0, 1'b1));
      for (int j = 1; j < 18; j++)
         srcQ[1].push_back(mk(64'hD000_0000_0000_0000 + 64'(j), 1'b0, j == 17, 1'b0));
      ordExp.push_back(1);
      expGrant = 3'b010; expGrantOn = 1'b1;
      drive();
      runDrain("dmaDrain", 100);
      expGrantOn = 1'b0;
      check("dmaTxCount", 64'(txCount), 64'(18));
      check("dmaTxSpan", 64'(txLast - txFirst), 64'(17));
      check("dmaAccSpan", 64'(accLast - accFirst), 64'(17));

      // Round-robin between 1 and 2 (rrPtr is now 2), with requester 0 cutting in mid-packet
      addPkt(1, 4, 64'h1100); addPkt(1, 4, 64'h1200);
      addPkt(2, 4, 64'h2100); addPkt(2, 4, 64'h2200);
      ordExp.push_back(2);
      drive();
      step();
      step();
      addPkt(0, 2, 64'h0100);
      ordExp.push_back(0); ordExp.push_back(1); ordExp.push_back(2); ordExp.push_back(1);
      drive();
      runDrain("rrDrain", 200);

      // Meter update under backpressure: hard stall first, then random txReady
      clrStats();
      srcQ[2].push_back(mk(MHDR, 1'b1, 1'b0, 1'b1));
      srcQ[2].push_back(mk(64'(8) * MTRBASE, 1'b0, 1'b0, 1'b0));
      srcQ[2].push_back(mk(64'd1, 1'b0, 1'b0, 1'b0));
      srcQ[2].push_back(mk(64'd0, 1'b0, 1'b1, 1'b0));
      ordExp.push_back(2);
      txHold = 1'b0;
      drive();
      repeat (5) step();
      check("stallAccepted", 64'(accCount), 64'(2));
      check("stallNoTx", 64'(txCount), 64'(0));
      txRand = 1'b1;
      runDrain("meterDrain", 200);
      txRand = 1'b0;
      txHold = 1'b1;
      drive();

      // Back-to-back single-beat packets on requester 0
      clrStats();
      for (int j = 0; j < 6; j++) begin
         addPkt(0, 1, 64'hC0C0_0000_0000_0000 + 64'(j * 16));
         ordExp.push_back(0);
      end
      expGrant = 3'b001; expGrantOn = 1'b1;
      drive();
      runDrain("singleDrain", 50);
      expGrantOn = 1'b0;
      check("singleAccCount", 64'(accCount), 64'(6));
      check("singleAccSpan", 64'(accLast - accFirst), 64'(5));
      check("singleTxSpan", 64'(txLast - txFirst), 64'(5));

      // Owner raises SOP on its third beat
      check("protoErrBefore", 64'(protoErr_out), 64'(0));
      srcQ[1].push_back(mk(64'hE000, 1'b1, 1'b0, 1'b1));
      srcQ[1].push_back(mk(64'hE001, 1'b0, 1'b0, 1'b0));
      srcQ[1].push_back(mk(64'hE002, 1'b1, 1'b0, 1'b0));
      srcQ[1].push_back(mk(64'hE003, 1'b0, 1'b0, 1'b0));
      srcQ[1].push_back(mk(64'hE004, 1'b0, 1'b1, 1'b0));
      ordExp.push_back(1);
      drive();
      runDrain("protoDrain", 50);
      check("protoErrSet", 64'(protoErr_out), 64'(1));
      repeat (3) step();
      check("protoErrSticky", 64'(protoErr_out), 64'(1));

      // Reset mid-packet (rrPtr is 2 beforehand), then 1 must beat 2 from a cleared pointer
      addPkt(1, 6, 64'hF000);
      ordExp.push_back(1);
      drive();
      repeat (3) step();
      check("protoErrPreReset", 64'(protoErr_out), 64'(1));
      pulseReset();
      addPkt(1, 2, 64'h1300);
      addPkt(2, 2, 64'h2300);
      ordExp.push_back(1); ordExp.push_back(2);
      drive();
      runDrain("postResetDrain", 50);
      addPkt(2, 3, 64'h2400);
      ordExp.push_back(2);
      drive();
      runDrain("req2Drain", 50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
